// File: rtl/m_seq_adder.sv
// Digit-serial adder/subtractor: W-bit operands processed D bits per clock,
// least significant digit first, with a registered carry between digits.
module m_seq_adder #(
  parameter int W = 8,
  parameter int D = 2
) (
  input  logic         w_clk,
  input  logic         w_rst,
  input  logic         w_start,
  input  logic         w_sub,
  input  logic [W-1:0] w_a,
  input  logic [W-1:0] w_b,
  input  logic         w_cin,
  output logic         w_ready,
  output logic         w_valid,
  output logic [W-1:0] w_s,
  output logic         w_cout,
  output logic         w_ovf
);

  localparam int N  = W / D;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] K_LAST = CW'(N - 1);

  if (W < 1 || D < 1 || D > W || (W % D) != 0) begin : g_param_err
    $error("m_seq_adder: W must be >= 1 and a multiple of D, with 1 <= D <= W");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  k_q, k_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic           c_q, c_d;
  logic [W-1:0]   s_q, s_d;
  logic           cout_q, cout_d;
  logic           ovf_q, ovf_d;
  logic           valid_q, valid_d;
  logic           ready_q, ready_d;

  logic [D-1:0]   dig_a, dig_b, dig_s;
  logic [D:0]     ch;

  // Select the active digit with constant slices so the mux stays a plain decode.
  always_comb begin
    dig_a = '0;
    dig_b = '0;
    for (int j = 0; j < N; j++) begin
      if (k_q == CW'(j)) begin
        dig_a = a_q[j*D +: D];
        dig_b = b_q[j*D +: D];
      end
    end
  end

  always_comb begin
    ch    = '0;
    dig_s = '0;
    ch[0] = c_q;
    for (int i = 0; i < D; i++) begin
      dig_s[i]  = dig_a[i] ^ dig_b[i] ^ ch[i];
      ch[i+1]   = (dig_a[i] & dig_b[i]) | (ch[i] & (dig_a[i] ^ dig_b[i]));
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_start) begin
          a_d     = w_a;
          b_d     = w_b ^ {W{w_sub}};
          c_d     = w_sub ? 1'b1 : w_cin;
          k_d     = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        for (int j = 0; j < N; j++) begin
          if (k_q == CW'(j)) s_d[j*D +: D] = dig_s;
        end
        c_d = ch[D];
        k_d = k_q + CW'(1);
        if (k_q == K_LAST) begin
          cout_d  = ch[D];
          ovf_d   = ch[D] ^ ch[D-1];
          valid_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign w_ready = ready_q;
  assign w_valid = valid_q;
  assign w_s     = s_q;
  assign w_cout  = cout_q;
  assign w_ovf   = ovf_q;

endmodule
